// File: rtl/lamp_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lamp_ramp_ctrl
// Purpose  : Brightness sequencer for the lamp-state decoder. Accepts target
//            levels from a manual panel and from the automatic light-sensor
//            path, arbitrates them (manual has priority and takes ownership
//            while its level is non-zero), and walks active_lights one level
//            per step tick toward the winning target.
// Optional : MOTION_TIMEOUT_EN - when defined, an automatically lit lamp that
//            holds its level with no motion pulse for TIMEOUT_STEPS step ticks
//            is ramped back down to 0. When undefined, motion is ignored.
// Ports    :
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   man_valid      in   1  manual request valid
//   man_level      in   4  manual target level
//   man_ready      out  1  always 1; manual request accepted when valid
//   auto_valid     in   1  automatic request valid
//   auto_level     in   4  automatic target level
//   auto_ready     out  1  !man_valid; auto accepted when valid & ready
//   motion         in   1  occupancy pulse (timeout feature only)
//   active_lights  out  4  current level driven to the lamp-state decoder
//   busy           out  1  high while the current level differs from target
//   mode           out  1  0 = auto owns target, 1 = manual owns target
// Parameters :
//   STEP_CYCLES    clock cycles per ramp step (>= 1)
//   TIMEOUT_STEPS  motionless step ticks before auto lamps turn off (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
module lamp_ramp_ctrl #(
  parameter int unsigned STEP_CYCLES   = 4,
  parameter int unsigned TIMEOUT_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       man_valid,
  input  logic [3:0] man_level,
  output logic       man_ready,
  input  logic       auto_valid,
  input  logic [3:0] auto_level,
  output logic       auto_ready,
  input  logic       motion,
  output logic [3:0] active_lights,
  output logic       busy,
  output logic       mode
);

  localparam int unsigned c_pre_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t               state_q,         state_d;
  logic [3:0]           active_lights_q, active_lights_d;
  logic [3:0]           target_q,        target_d;
  logic                 mode_q,          mode_d;
  logic [c_pre_w-1:0]   prescaler_q,     prescaler_d;

  // --------------------------------------------------------------------------
  // Handshake and arbitration
  // --------------------------------------------------------------------------
  logic       man_acc;
  logic       auto_acc;
  logic       acc_upd;      // an accept that is allowed to write the target
  logic [3:0] acc_target;
  logic       acc_mode;
  logic       tgt_changed;  // accept that actually moves the target
  logic       wrap;
  logic       step_tick;
  logic       timeout_hit;

  assign man_ready  = 1'b1;
  assign auto_ready = ~man_valid;

  always_comb begin
    man_acc    = man_valid;
    auto_acc   = auto_valid & ~man_valid;
    acc_upd    = 1'b0;
    acc_target = target_q;
    acc_mode   = mode_q;
    if (man_acc) begin
      acc_upd    = 1'b1;
      acc_target = man_level;
      // A manual zero hands ownership back to the automatic path.
      acc_mode   = (man_level != 4'd0);
    end else if (auto_acc && !mode_q) begin
      acc_upd    = 1'b1;
      acc_target = auto_level;
    end
    // In manual mode an auto accept still completes the handshake but is
    // dropped, so it never reaches acc_upd.
    tgt_changed = acc_upd && (acc_target != target_q);
    wrap        = (prescaler_q == c_pre_last);
    // A target-changing accept restarts the prescaler, so the wrap that would
    // have happened in the same cycle is cancelled; the first step then lands
    // exactly STEP_CYCLES cycles after the accept.
    step_tick   = wrap && !tgt_changed;
  end

  // --------------------------------------------------------------------------
  // Optional motion timeout
  // --------------------------------------------------------------------------
`ifdef MOTION_TIMEOUT_EN
  localparam int unsigned c_idle_w = (TIMEOUT_STEPS > 1) ? $clog2(TIMEOUT_STEPS + 1) : 1;
  localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT_STEPS - 1);

  logic [c_idle_w-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    // Counting only happens while an auto-owned lamp sits at a lit level;
    // everywhere else the counter is pinned at zero.
    if (!mode_q && (state_q == ST_HOLD)) begin
      if (motion) begin
        idle_cnt_d = '0;
      end else if (step_tick) begin
        if (idle_cnt_q == c_idle_last) begin
          timeout_hit = 1'b1;
          idle_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_d = idle_cnt_q;
      end
    end
    if (auto_acc) begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  // Auto lamps hold their level until the next request; motion is unused.
  logic unused_motion;
  assign unused_motion = motion;
  assign timeout_hit   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Target, mode, prescaler and level datapath
  // --------------------------------------------------------------------------
  always_comb begin
    target_d = target_q;
    mode_d   = mode_q;
    if (timeout_hit) begin
      target_d = 4'd0;
    end
    // A fresh request in the same cycle takes precedence over the timeout.
    if (acc_upd) begin
      target_d = acc_target;
      mode_d   = acc_mode;
    end

    if (tgt_changed || wrap) begin
      prescaler_d = '0;
    end else begin
      prescaler_d = prescaler_q + 1'b1;
    end

    // One level per tick toward the target that was in force before this
    // edge; the comparison guards keep the level from ever wrapping.
    active_lights_d = active_lights_q;
    if (step_tick) begin
      if (active_lights_q < target_q) begin
        active_lights_d = active_lights_q + 4'd1;
      end else if (active_lights_q > target_q) begin
        active_lights_d = active_lights_q - 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State machine: state is a pure function of the next level and target
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (active_lights_d != target_d) begin
      state_d = ST_RAMP;
    end else if (target_d == 4'd0) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      active_lights_q <= 4'd0;
      target_q        <= 4'd0;
      mode_q          <= 1'b0;
      prescaler_q     <= '0;
    end else begin
      state_q         <= state_d;
      active_lights_q <= active_lights_d;
      target_q        <= target_d;
      mode_q          <= mode_d;
      prescaler_q     <= prescaler_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign active_lights = active_lights_q;
  assign busy          = (state_q == ST_RAMP);
  assign mode          = mode_q;

endmodule
`default_nettype wire
